// File: rtl/_crc8_serial.sv
// ----------------------------------------------------------------------------
// _crc8_serial
//   Bit-serial CRC-8 generator. Accepts one byte per valid/ready handshake and
//   folds it into a running CRC one bit per clock, MSB first, then pulses
//   `done` for one cycle with the updated CRC on `crc_out`. The running CRC is
//   kept between bytes so a message can be chained; `clear` restarts it at
//   INIT while the block is idle.
//
//   The feedback XOR and the per-bit polynomial AND/XOR network are built
//   from the primitive gates _xor2 and _and2, defined at the top of this file.
//
// Parameters
//   POLY      generator polynomial, implicit x^8 term dropped
//   INIT      CRC value after reset and after clear
//
// Ports
//   clk       in   1  rising-edge clock
//   reset_n   in   1  asynchronous active-low reset
//   clear     in   1  restart running CRC at INIT (idle only)
//   in_valid  in   1  in_data valid this cycle
//   in_data   in   8  byte to fold in, MSB first
//   in_ready  out  1  block accepts a byte this cycle
//   done      out  1  one-cycle pulse, crc_out just updated
//   crc_out   out  8  CRC after the last completed byte
// ----------------------------------------------------------------------------

// Two-input XOR primitive.
module _xor2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// Two-input AND primitive.
module _and2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module _crc8_serial #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       done,
  output logic [7:0] crc_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t     state;
  logic [7:0] crc;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  // Combinational next-CRC for one bit step, built from gate primitives.
  logic       fb;
  logic [7:0] crc_shl;
  logic [7:0] poly_mask;
  logic [7:0] crc_next;

  assign crc_shl = {crc[6:0], 1'b0};

  _xor2 u_fb (
    .a (crc[7]),
    .b (shreg[7]),
    .y (fb)
  );

  for (genvar i = 0; i < 8; i++) begin : g_bit
    // Polynomial term is present on bit i only when the feedback bit is set.
    _and2 u_mask (
      .a (POLY[i]),
      .b (fb),
      .y (poly_mask[i])
    );
    _xor2 u_fold (
      .a (crc_shl[i]),
      .b (poly_mask[i]),
      .y (crc_next[i])
    );
  end

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      crc      <= INIT;
      crc_out  <= INIT;
      shreg    <= '0;
      bit_cnt  <= '0;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // clear is written first so a byte accepted in the same cycle is
          // folded from INIT.
          if (clear) begin
            crc <= INIT;
          end
          if (in_valid) begin
            shreg    <= in_data;
            bit_cnt  <= 3'd7;
            state    <= SHIFT;
            in_ready <= 1'b0;
          end
        end

        SHIFT: begin
          crc   <= crc_next;
          shreg <= {shreg[6:0], 1'b0};
          if (bit_cnt == 3'd0) begin
            state   <= DONE;
            done    <= 1'b1;
            crc_out <= crc_next;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end

        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end

        // NOTE: the unused code 2'b11 must not lock up the FSM, so it falls
        // back to IDLE with idle outputs.
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb__crc8_serial.sv
// ----------------------------------------------------------------------------
// tb__crc8_serial
//   Directed bench for _crc8_serial (POLY=8'h07, INIT=8'h00). Expected CRC
//   values are hand-computed constants; timing is checked against the
//   accept-edge-relative latency of the handshake.
// ----------------------------------------------------------------------------
module tb__crc8_serial;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       clear    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       done;
  logic [7:0] crc_out;

  int checks   = 0;
  int failures = 0;

  _crc8_serial #(
    .POLY (8'h07),
    .INIT (8'h00)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .done     (done),
    .crc_out  (crc_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse clear for one idle cycle; crc_out must not move.
  task automatic do_clear(input string tag, input logic [7:0] exp_out);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check({tag, "_clr_keeps_out"}, crc_out, exp_out);
  endtask

  // Send one byte and follow it to its done pulse.
  //   clr   : assert clear together with in_valid at the accept edge
  //   hold  : keep in_valid high afterwards (back-to-back chaining)
  //   noise : toggle in_valid/clear/in_data while the block is busy
  //   chk   : compare crc_out against exp_crc
  task automatic do_byte(input string tag, input logic [7:0] data,
                         input logic clr, input logic hold, input logic noise,
                         input logic chk, input logic [7:0] exp_crc);
    int k   = 0;
    int n   = 0;
    int low = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_ready"}, in_ready, 1);
    in_data  = data;
    clear    = clr;
    in_valid = 1'b1;
    @(posedge clk);   // accept edge T
    #1;
    clear = 1'b0;
    if (!hold) in_valid = 1'b0;
    while (n < 20) begin
      if (!in_ready) low++;
      if (done) break;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        clear    = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = hold;
    clear    = 1'b0;
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, low, 9);
    if (chk) check({tag, "_crc"}, crc_out, exp_crc);
    if (!hold) begin
      @(posedge clk);
      #1;
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_ready_again"}, in_ready, 1);
    end
  endtask

  initial begin
    int done_seen;
    logic [7:0] msg [9];
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

    // 1: reset values, during and after reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_done", done, 0);
    check("rst_crc", crc_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_done", done, 0);
    check("post_rst_crc", crc_out, 8'h00);

    // 2: single bytes from a cleared CRC
    do_clear("t2a", 8'h00);
    do_byte("b01", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);
    do_clear("t2b", 8'h07);
    do_byte("b80", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 8'h89);

    // 3: "123456789" back to back with in_valid held high
    do_clear("t3", 8'h89);
    for (int i = 0; i < 9; i++) begin
      do_byte("chain", msg[i], 1'b0, (i != 8), 1'b0, (i == 8), 8'hF4);
    end

    // 4: inputs toggled while busy have no effect
    do_clear("t4", 8'hF4);
    do_byte("busy", 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h07);

    // 5: clear together with in_valid after a prior byte
    do_byte("pre_ff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    do_byte("clr_valid", 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h07);

    // 6: reset mid-SHIFT
    @(negedge clk);
    in_data  = 8'h80;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_crc", crc_out, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    do_byte("after_rst", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
